// File: rtl/lisnoc_pkg.sv
//------------------------------------------------------------------------------
// lisnoc_pkg : shared LISNoC flit-type and arbiter-state definitions
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lisnoc_pkg;

  localparam int FLIT_TYPE_WIDTH = 2;
  localparam int MAX_FLIT_WIDTH  = 130;

  localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_HEADER  = 2'b01;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_LAST    = 2'b10;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_SINGLE  = 2'b11;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // The type field lives in the two MSBs of a flit of any width up to MAX_FLIT_WIDTH.
  function automatic logic [FLIT_TYPE_WIDTH-1:0] flit_type(input logic [MAX_FLIT_WIDTH-1:0] flit,
                                                           input int width);
    return FLIT_TYPE_WIDTH'(flit >> (width - FLIT_TYPE_WIDTH));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lisnoc_rr_select.sv
//------------------------------------------------------------------------------
// lisnoc_rr_select : combinational round-robin pick, scanning from last_grant+1
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lisnoc_rr_select
  import lisnoc_pkg::*;
#(
  parameter int PORTS = 4
) (
  input  logic [PORTS-1:0]         req,
  input  logic [$clog2(PORTS)-1:0] last_grant,
  output logic [$clog2(PORTS)-1:0] sel,
  output logic                     any
);

  localparam int SEL_W = $clog2(PORTS);

  int               w_idx;
  logic [PORTS-1:0] w_shift;

  // Scan from the farthest candidate down so the nearest one after last_grant wins.
  always_comb begin
    sel     = '0;
    any     = 1'b0;
    w_idx   = 0;
    w_shift = '0;
    for (int k = PORTS; k >= 1; k--) begin
      w_idx   = (int'(last_grant) + k) % PORTS;
      w_shift = req >> w_idx;
      if (w_shift[0]) begin
        sel = SEL_W'(w_idx);
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lisnoc_packet_arbiter.sv
//------------------------------------------------------------------------------
// lisnoc_packet_arbiter : wormhole round-robin arbiter sharing one LISNoC link
// Revision              : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lisnoc_packet_arbiter
  import lisnoc_pkg::*;
#(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int PORTS           = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PORTS*(FLIT_DATA_WIDTH+2)-1:0]  in_flit,
  input  logic [PORTS-1:0]                      in_valid,
  output logic [PORTS-1:0]                      in_ready,
  output logic [FLIT_DATA_WIDTH+1:0]            out_flit,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [$clog2(PORTS)-1:0]              active_port,
  output logic                                  busy,
  output logic                                  err
);

  localparam int FLIT_WIDTH = FLIT_DATA_WIDTH + 2;
  localparam int SEL_W      = $clog2(PORTS);

  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_sel_q;
  logic [SEL_W-1:0] r_last_grant;
  logic             r_err;

  logic [PORTS-1:0] w_elig;
  logic [PORTS-1:0] w_bad;
  logic [SEL_W-1:0] w_rr_sel;
  logic             w_rr_any;
  logic [SEL_W-1:0] w_sel;
  logic             w_sel_valid;
  logic [PORTS-1:0] w_selq_shift;
  logic             w_selq_valid;
  logic [1:0]       w_sel_type;
  logic             w_xfer;

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    logic [1:0] w_type;
    assign w_type    = flit_type(MAX_FLIT_WIDTH'(in_flit[i*FLIT_WIDTH +: FLIT_WIDTH]), FLIT_WIDTH);
    assign w_elig[i] = in_valid[i] & ((w_type == FLIT_HEADER) | (w_type == FLIT_SINGLE));
    assign w_bad[i]  = in_valid[i] & ((w_type == FLIT_PAYLOAD) | (w_type == FLIT_LAST));
  end

  lisnoc_rr_select #(
    .PORTS (PORTS)
  ) u_rr_select (
    .req        (w_elig),
    .last_grant (r_last_grant),
    .sel        (w_rr_sel),
    .any        (w_rr_any)
  );

  assign w_selq_shift = in_valid >> r_sel_q;
  assign w_selq_valid = w_selq_shift[0];

  // Idle with nobody eligible still points at last_grant so active_port stays meaningful.
  always_comb begin
    w_sel       = r_sel_q;
    w_sel_valid = w_selq_valid;
    if (r_state == IDLE) begin
      w_sel       = w_rr_any ? w_rr_sel : r_last_grant;
      w_sel_valid = w_rr_any;
    end
  end

  assign out_flit    = FLIT_WIDTH'(in_flit >> (int'(w_sel) * FLIT_WIDTH));
  assign out_valid   = ~rst & w_sel_valid;
  assign in_ready    = (rst || ((r_state == IDLE) && !w_rr_any)) ? '0
                                                                 : (PORTS'(out_ready) << w_sel);
  assign active_port = rst ? '0 : w_sel;
  assign busy        = ~rst & (r_state != IDLE);
  assign err         = r_err;
  assign w_sel_type  = flit_type(MAX_FLIT_WIDTH'(out_flit), FLIT_WIDTH);
  assign w_xfer      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel_q      <= '0;
      r_last_grant <= SEL_W'(PORTS - 1);
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_bad) r_err <= 1'b1;
          if (w_rr_any) begin
            r_sel_q <= w_rr_sel;
            if (!out_ready)                    r_state      <= HOLD;
            else if (w_sel_type == FLIT_SINGLE) r_last_grant <= w_rr_sel;
            else                               r_state      <= LOCKED;
          end
        end
        HOLD: begin
          // The held source withdrawing its flit breaks valid/ready; release the grant.
          if (!w_selq_valid) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (out_ready) begin
            if (w_sel_type == FLIT_HEADER) begin
              r_state <= LOCKED;
            end else begin
              r_state      <= IDLE;
              r_last_grant <= r_sel_q;
              if (w_sel_type != FLIT_SINGLE) r_err <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (w_xfer) begin
            if (w_sel_type == FLIT_LAST) begin
              r_state      <= IDLE;
              r_last_grant <= r_sel_q;
            end else if (w_sel_type != FLIT_PAYLOAD) begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lisnoc_packet_arbiter.sv
//------------------------------------------------------------------------------
// tb_lisnoc_packet_arbiter : scoreboard bench with a cycle-level reference model
// Revision                 : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lisnoc_packet_arbiter;
  import lisnoc_pkg::*;

  localparam int P  = 4;
  localparam int DW = 32;
  localparam int FW = DW + 2;
  localparam int TW = P * FW;
  localparam int SW = $clog2(P);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] in_flit = '0;
  logic [P-1:0]  in_valid = '0;
  logic [P-1:0]  in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] active_port;
  logic          busy;
  logic          err;

  lisnoc_packet_arbiter #(
    .FLIT_DATA_WIDTH (DW),
    .PORTS           (P)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit     (in_flit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_flit    (out_flit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .active_port (active_port),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ov;
    logic [P-1:0]  rdy;
    logic          bsy;
    logic [SW-1:0] act;
    logic          er;
  } stat_t;

  stat_t         sq[$];
  logic [FW-1:0] xq[$];
  int            errors = 0;
  int            checks = 0;

  // Reference model: owner port (-1 when the link is free), whether its header has passed.
  int            m_g   = -1;
  bit            m_lk  = 1'b0;
  int            m_lg  = P - 1;
  bit            m_err = 1'b0;
  logic [P-1:0]  exp_rdy = '0;

  logic [FW-1:0] srcq[P][$];
  bit            pend[P];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] flit_of(input logic [TW-1:0] f, input int p);
    return FW'(f >> (p * FW));
  endfunction

  function automatic logic [1:0] ty(input logic [TW-1:0] f, input int p);
    logic [FW-1:0] x;
    x = flit_of(f, p);
    return x[FW-1 -: 2];
  endfunction

  function automatic logic [TW-1:0] put(input logic [TW-1:0] f, input int p, input logic [FW-1:0] x);
    logic [TW-1:0] m;
    m = TW'({FW{1'b1}}) << (p * FW);
    return (f & ~m) | (TW'(x) << (p * FW));
  endfunction

  task automatic step(input logic [P-1:0] v, input logic [TW-1:0] f, input logic ordy, input logic r);
    stat_t      s;
    int         w;
    bit         bad;
    logic [1:0] t;
    @(negedge clk);
    rst = r; in_valid = v; in_flit = f; out_ready = ordy;
    s.ov = 1'b0; s.rdy = '0; s.bsy = 1'b0; s.act = '0; s.er = m_err;
    if (r) begin
      sq.push_back(s);
      exp_rdy = '0;
      m_g = -1; m_lk = 1'b0; m_lg = P - 1; m_err = 1'b0;
      return;
    end
    if (m_g < 0) begin
      w = -1; bad = 1'b0;
      for (int k = 1; k <= P; k++) begin
        int i = (m_lg + k) % P;
        t = ty(f, i);
        if (w < 0 && v[i] && (t == FLIT_HEADER || t == FLIT_SINGLE)) w = i;
      end
      for (int i = 0; i < P; i++) begin
        t = ty(f, i);
        if (v[i] && (t == FLIT_PAYLOAD || t == FLIT_LAST)) bad = 1'b1;
      end
      s.ov  = (w >= 0);
      s.act = (w >= 0) ? SW'(w) : SW'(m_lg);
      if (w >= 0 && ordy) s.rdy[w] = 1'b1;
      sq.push_back(s);
      exp_rdy = s.rdy;
      if (bad) m_err = 1'b1;
      if (w >= 0) begin
        if (ordy) begin
          xq.push_back(flit_of(f, w));
          if (ty(f, w) == FLIT_SINGLE) m_lg = w;
          else begin m_g = w; m_lk = 1'b1; end
        end else begin
          m_g = w; m_lk = 1'b0;
        end
      end
    end else begin
      s.bsy = 1'b1; s.act = SW'(m_g); s.ov = v[m_g]; s.rdy[m_g] = ordy;
      sq.push_back(s);
      exp_rdy = s.rdy;
      t = ty(f, m_g);
      if (v[m_g] && ordy) xq.push_back(flit_of(f, m_g));
      if (!m_lk) begin
        if (!v[m_g]) begin m_err = 1'b1; m_g = -1; end
        else if (ordy) begin
          if (t == FLIT_SINGLE) begin m_lg = m_g; m_g = -1; end
          else m_lk = 1'b1;
        end
      end else if (v[m_g] && ordy) begin
        if (t == FLIT_LAST) begin m_lg = m_g; m_g = -1; m_lk = 1'b0; end
        else if (t != FLIT_PAYLOAD) m_err = 1'b1;
      end
    end
  endtask

  initial begin : monitor
    stat_t s;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        check("out_valid",   64'(out_valid),   64'(s.ov));
        check("in_ready",    64'(in_ready),    64'(s.rdy));
        check("busy",        64'(busy),        64'(s.bsy));
        check("active_port", 64'(active_port), 64'(s.act));
        check("err",         64'(err),         64'(s.er));
        if (out_valid && out_ready) begin
          if (xq.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_flit: got unexpected flit %0h expected none", out_flit);
          end else begin
            check("out_flit", 64'(out_flit), 64'(xq.pop_front()));
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [TW-1:0] F;
    logic [P-1:0]  v;
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);

    // single flit from port 1
    F = put('0, 1, {FLIT_SINGLE, 32'h0000_0011});
    step(4'b0010, F, 1'b1, 1'b0);

    // three simultaneous singles rotate 2, 3, 0
    F = put('0, 0, {FLIT_SINGLE, 32'hA0});
    F = put(F, 2, {FLIT_SINGLE, 32'hA2});
    F = put(F, 3, {FLIT_SINGLE, 32'hA3});
    step(4'b1101, F, 1'b1, 1'b0);
    step(4'b1001, F, 1'b1, 1'b0);
    step(4'b0001, F, 1'b1, 1'b0);

    // port 0 packet keeps the link while port 3 waits with a header
    F = put('0, 0, {FLIT_HEADER, 32'hB0});
    step(4'b0001, F, 1'b1, 1'b0);
    F = put(F, 3, {FLIT_HEADER, 32'hC3});
    F = put(F, 0, {FLIT_PAYLOAD, 32'hB1});
    step(4'b1001, F, 1'b1, 1'b0);
    F = put(F, 0, {FLIT_PAYLOAD, 32'hB2});
    step(4'b1001, F, 1'b1, 1'b0);
    F = put(F, 0, {FLIT_LAST, 32'hB3});
    step(4'b1001, F, 1'b1, 1'b0);
    step(4'b1000, F, 1'b1, 1'b0);
    F = put(F, 3, {FLIT_LAST, 32'hC4});
    step(4'b1000, F, 1'b1, 1'b0);

    // stalled grant is frozen against a higher-priority newcomer
    F = put('0, 0, {FLIT_SINGLE, 32'hD0});
    step(4'b0001, F, 1'b1, 1'b0);
    F = put('0, 2, {FLIT_HEADER, 32'hE2});
    step(4'b0100, F, 1'b0, 1'b0);
    F = put(F, 1, {FLIT_HEADER, 32'hE1});
    step(4'b0110, F, 1'b0, 1'b0);
    step(4'b0110, F, 1'b1, 1'b0);
    F = put(F, 2, {FLIT_LAST, 32'hE3});
    step(4'b0110, F, 1'b1, 1'b0);
    step(4'b0010, F, 1'b1, 1'b0);
    F = put(F, 1, {FLIT_LAST, 32'hE4});
    step(4'b0010, F, 1'b1, 1'b0);

    // payload with no packet open is refused and latches err
    F = put('0, 1, {FLIT_PAYLOAD, 32'h99});
    step(4'b0010, F, 1'b1, 1'b0);
    step(4'b0010, F, 1'b1, 1'b0);
    step(4'b0000, F, 1'b1, 1'b0);
    step(4'b0000, F, 1'b1, 1'b0);

    // held source drops valid before its flit is taken
    F = put('0, 3, {FLIT_HEADER, 32'hF3});
    step(4'b1000, F, 1'b0, 1'b0);
    step(4'b0000, F, 1'b1, 1'b0);
    step(4'b0000, F, 1'b1, 1'b0);

    // reset mid-packet, then an immediate single from port 3
    F = put('0, 0, {FLIT_HEADER, 32'h70});
    step(4'b0001, F, 1'b1, 1'b0);
    F = put(F, 0, {FLIT_PAYLOAD, 32'h71});
    step(4'b0001, F, 1'b1, 1'b0);
    step(4'b0001, F, 1'b1, 1'b1);
    F = put('0, 3, {FLIT_SINGLE, 32'h73});
    step(4'b1000, F, 1'b1, 1'b0);

    // randomized legal traffic
    step('0, '0, 1'b0, 1'b1);
    for (int p = 0; p < P; p++) begin
      srcq[p].delete();
      pend[p] = 1'b0;
    end
    for (int n = 0; n < 1500; n++) begin
      F = '0; v = '0;
      for (int p = 0; p < P; p++) begin
        if (!pend[p]) begin
          if (srcq[p].size() == 0 && $urandom_range(0, 3) == 0) begin
            int len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
              logic [1:0] t;
              t = (len == 1) ? FLIT_SINGLE : (j == 0) ? FLIT_HEADER :
                  (j == len - 1) ? FLIT_LAST : FLIT_PAYLOAD;
              srcq[p].push_back({t, 8'(p), 8'(j), 16'($urandom)});
            end
          end
          if (srcq[p].size() > 0 && $urandom_range(0, 9) < 6) pend[p] = 1'b1;
        end
        if (srcq[p].size() > 0) F = put(F, p, srcq[p][0]);
        v[p] = pend[p];
      end
      step(v, F, ($urandom_range(0, 3) != 0), 1'b0);
      for (int p = 0; p < P; p++) begin
        if (v[p] && exp_rdy[p]) begin
          void'(srcq[p].pop_front());
          pend[p] = 1'b0;
        end
      end
    end

    step('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #5;
    check("leftover_expected_flits", 64'(xq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
